// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaled period counter, per-channel double-buffered duty.
// Define PWM_CENTER_ALIGN_EN to add the `center` input for up/down (symmetric) counting.
module pwm_multi #(
  parameter  int WIDTH      = 8,
  parameter  int CHANNELS   = 4,
  parameter  int PRESCALE_W = 8,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
`ifdef PWM_CENTER_ALIGN_EN
  input  logic                  center,
`endif
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [WIDTH-1:0]      period,
  input  logic                  duty_valid,
  input  logic [CH_W-1:0]       duty_ch,
  input  logic [WIDTH-1:0]      duty_val,
  output logic                  duty_ready,
  output logic [CHANNELS-1:0]   pwm,
  output logic                  period_tick
);

  logic [PRESCALE_W-1:0] r_pre_cnt;
  logic [WIDTH-1:0]      r_cnt;
  logic [WIDTH-1:0]      r_shadow [CHANNELS];
  logic [WIDTH-1:0]      r_active [CHANNELS];
  logic [CHANNELS-1:0]   r_pending;
  logic [CHANNELS-1:0]   r_pwm;
  logic                  r_period_tick;

  logic                  w_tick;
  logic                  w_boundary;
  logic                  w_xfer;
  logic                  w_ch_valid;
  logic                  w_sel_pending;
  logic                  w_write;
  logic [WIDTH-1:0]      w_cnt_next;

`ifdef PWM_CENTER_ALIGN_EN
  logic                  r_center;
  logic                  r_dir_down;
  logic                  w_dir_next;
`endif

  assign w_tick = en && (r_pre_cnt == prescale);

  // A prescale lowered below the running count wraps at once instead of rolling over.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_pre_cnt <= '0;
    else if (!en || r_pre_cnt >= prescale)  r_pre_cnt <= '0;
    else                                    r_pre_cnt <= r_pre_cnt + 1'b1;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_cnt_next = r_cnt;
    w_boundary = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
    w_dir_next = r_dir_down;
`endif
    if (w_tick) begin
`ifdef PWM_CENTER_ALIGN_EN
      if (r_center) begin
        if (r_dir_down) begin
          w_cnt_next = r_cnt - 1'b1;
          if (r_cnt <= WIDTH'(1)) begin
            w_cnt_next = '0;
            w_boundary = 1'b1;
            w_dir_next = 1'b0;
          end
        end else if (r_cnt >= period) begin
          if (period <= WIDTH'(1)) begin
            w_cnt_next = '0;
            w_boundary = 1'b1;
          end else begin
            w_cnt_next = period - 1'b1;
            w_dir_next = 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end else begin
`else
      begin
`endif
        // A count left above a newly lowered period wraps here and counts as a boundary.
        if (r_cnt >= period) begin
          w_cnt_next = '0;
          w_boundary = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt         <= '0;
      r_period_tick <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      r_center      <= 1'b0;
      r_dir_down    <= 1'b0;
`endif
    end else begin
      r_period_tick <= w_boundary;
      r_cnt         <= en ? w_cnt_next : '0;
`ifdef PWM_CENTER_ALIGN_EN
      r_dir_down    <= en ? w_dir_next : 1'b0;
      if (!en || w_boundary) r_center <= center;
`endif
    end
  end

  // Out-of-range channel numbers match nothing: ready stays high and the write is dropped.
  always_comb begin
    w_ch_valid    = 1'b0;
    w_sel_pending = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (duty_ch == CH_W'(i)) begin
        w_ch_valid    = 1'b1;
        w_sel_pending = r_pending[i];
      end
    end
  end

  assign duty_ready = !rst && !w_sel_pending;
  assign w_write    = duty_valid && duty_ready && w_ch_valid;
  assign w_xfer     = !en || w_boundary;

  // NOTE: duty storage is a few flops per channel, not a RAM, so it is cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_xfer && r_pending[i]) begin
          r_active[i]  <= r_shadow[i];
          r_pending[i] <= 1'b0;
        end
        if (w_write && duty_ch == CH_W'(i)) begin
          r_shadow[i]  <= duty_val;
          r_pending[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) r_pwm[i] <= en && (r_cnt < r_active[i]);
    end
  end

  assign pwm         = r_pwm;
  assign period_tick = r_period_tick;

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: per-cycle expected pwm/period_tick pushed to a
// scoreboard from the duty/period/prescale model, then popped against the DUT.
module tb_pwm_multi;
  localparam int W   = 8;
  localparam int CH  = 4;
  localparam int PW  = 8;
  localparam int CHW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [PW-1:0] prescale;
  logic [W-1:0]  period;
  logic          duty_valid;
  logic [CHW-1:0] duty_ch;
  logic [W-1:0]  duty_val;
  logic          duty_ready;
  logic [CH-1:0] pwm;
  logic          period_tick;
`ifdef PWM_CENTER_ALIGN_EN
  logic          center;
`endif

  typedef struct {
    string         tag;
    logic [CH-1:0] pwm;
    logic          tick;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_duty[CH];
  bit   m_center = 1'b0;

  always #5 clk = ~clk;

  pwm_multi #(.WIDTH(W), .CHANNELS(CH), .PRESCALE_W(PW)) dut (
`ifdef PWM_CENTER_ALIGN_EN
    .center      (center),
`endif
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .prescale    (prescale),
    .period      (period),
    .duty_valid  (duty_valid),
    .duty_ch     (duty_ch),
    .duty_val    (duty_val),
    .duty_ready  (duty_ready),
    .pwm         (pwm),
    .period_tick (period_tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Expected pwm level in window cycle c (1-based, c = 1 reflects count 0 after a boundary).
  function automatic logic exp_bit(input int duty, input int c);
    int ps1 = int'(prescale) + 1;
    int per = int'(period);
    int k   = (c - 1) / ps1;
    int cv;
    if (m_center) begin
      cv = (k <= per) ? k : 2 * per - k;
      return cv < duty;
    end
    return c <= ((duty < per + 1) ? duty : per + 1) * ps1;
  endfunction

  function automatic int win_len();
    if (m_center) return 2 * int'(period) * (int'(prescale) + 1);
    return (int'(period) + 1) * (int'(prescale) + 1);
  endfunction

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      check({e.tag, "_pwm"},  32'(pwm),         32'(e.pwm));
      check({e.tag, "_tick"}, 32'(period_tick), 32'(e.tick));
    end
  endtask

  // Caller sits at the negedge of window cycle first_c-1.
  task automatic run_window(input int first_c, input string tag);
    int   len = win_len();
    exp_t e;
    for (int c = first_c; c <= len; c++) begin
      e.tag  = tag;
      e.tick = (c == len);
      for (int i = 0; i < CH; i++) e.pwm[i] = exp_bit(m_duty[i], c);
      sb.push_back(e);
    end
    drain();
  endtask

  task automatic expect_flat(input int n, input string tag);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      e.tag  = tag;
      e.pwm  = '0;
      e.tick = 1'b0;
      sb.push_back(e);
    end
    drain();
  endtask

  task automatic wait_tick();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!period_tick && k < 2000);
    if (!period_tick) check("tick_timeout", 32'(period_tick), 32'd1);
  endtask

  task automatic run_periods(input int n, input string tag);
    wait_tick();
    repeat (n) run_window(1, tag);
  endtask

  task automatic write_duty(input int ch, input int v, input string tag);
    duty_valid = 1'b1;
    duty_ch    = CHW'(ch);
    duty_val   = W'(v);
    #1 check({tag, "_ready"}, 32'(duty_ready), 32'd1);
    @(negedge clk);
    duty_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int stall;
    rst        = 1'b1;
    en         = 1'b0;
    prescale   = '0;
    period     = W'(9);
    duty_valid = 1'b0;
    duty_ch    = '0;
    duty_val   = '0;
`ifdef PWM_CENTER_ALIGN_EN
    center     = 1'b0;
`endif
    for (int i = 0; i < CH; i++) m_duty[i] = 0;

    repeat (2) @(negedge clk);
    check("rst_pwm",   32'(pwm),         32'd0);
    check("rst_tick",  32'(period_tick), 32'd0);
    check("rst_ready", 32'(duty_ready),  32'd0);
    rst = 1'b0;
    #1 check("rel_ready", 32'(duty_ready), 32'd1);
    @(negedge clk);
    check("idle_pwm", 32'(pwm), 32'd0);

    // Basic duty: period 10, ch0 high 3 of 10.
    en = 1'b1;
    write_duty(0, 3, "wr_basic");
    m_duty[0] = 3;
    run_periods(2, "basic");

    // Backpressure: second write to ch1 stalls until the boundary.
    write_duty(1, 2, "wr_bp1");
    duty_valid = 1'b1;
    duty_ch    = CHW'(1);
    duty_val   = W'(7);
    #1 check("bp_stall", 32'(duty_ready), 32'd0);
    stall = 0;
    while (!duty_ready && stall < 100) begin
      @(negedge clk);
      stall++;
    end
    check("bp_stall_len",    32'(stall),       32'd9);
    check("bp_release_tick", 32'(period_tick), 32'd1);
    @(negedge clk);
    duty_valid = 1'b0;
    m_duty[1] = 2;
    run_window(2, "bp_old");
    m_duty[1] = 7;
    run_window(1, "bp_new");

    // Extremes at period 4, then prescale 3 (20-cycle period).
    period = W'(4);
    write_duty(0, 0,   "wr_ext0");
    write_duty(1, 5,   "wr_ext1");
    write_duty(2, 255, "wr_ext2");
    write_duty(3, 4,   "wr_ext3");
    m_duty = '{0, 5, 255, 4};
    run_periods(2, "ext");
    prescale = PW'(3);
    run_periods(1, "ps3");

    // Enable gating: write while disabled transfers at once, restart at count 0.
    en       = 1'b0;
    prescale = '0;
    period   = W'(9);
    @(negedge clk);
    check("dis_pwm", 32'(pwm), 32'd0);
    write_duty(2, 4, "wr_dis");
    m_duty[2] = 4;
    expect_flat(4, "dis");
    en = 1'b1;
    run_window(1, "reen");
    run_window(1, "reen2");

    // Asynchronous reset mid-period.
    repeat (2) @(negedge clk);
    check("pre_rst_pwm", 32'(pwm), 32'b1110);
    #2 rst = 1'b1;
    #1;
    check("amid_pwm",   32'(pwm),         32'd0);
    check("amid_ready", 32'(duty_ready),  32'd0);
    check("amid_tick",  32'(period_tick), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rel2_ready", 32'(duty_ready), 32'd1);
    for (int i = 0; i < CH; i++) m_duty[i] = 0;
    run_window(1, "post_rst");

    // Period 0: every tick is a boundary.
    period = '0;
    write_duty(0, 1, "wr_p0");
    m_duty[0] = 1;
    run_periods(4, "per0");

`ifdef PWM_CENTER_ALIGN_EN
    // Center-aligned: period 4, duty 2 -> 8-cycle period, high on counts 0,1,1.
    period = W'(4);
    center = 1'b1;
    write_duty(0, 2, "wr_ctr");
    m_duty[0] = 2;
    wait_tick();
    m_center = 1'b1;
    run_window(1, "ctr");
    run_window(1, "ctr2");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
